// File: rtl/logic_gate_pipe.sv
// rtl/logic_gate_pipe.sv - bitwise gate with chain accumulator and handshaked result FIFO
// Optional feature macro: LGP_PARITY_EN adds the O_PAR even-parity output.
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [2:0]       OP,
    input  logic             ACC,
    input  logic             FIRST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] O,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [CNT_W-1:0] COUNT
`ifdef LGP_PARITY_EN
    ,
    output logic             O_PAR
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_OCC = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             accept;
    logic             pop;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] result_d;

    // IN_READY depends only on stored occupancy, never on OUT_READY.
    assign IN_READY  = (occ_q < DEPTH_OCC) & ~RST;
    assign OUT_VALID = (occ_q != '0);
    assign accept    = IN_VALID & IN_READY;
    assign pop       = OUT_VALID & OUT_READY;
    assign O         = OUT_VALID ? mem_q[rd_ptr_q] : '0;
    assign COUNT     = count_q;

`ifdef LGP_PARITY_EN
    assign O_PAR = ^O;
`endif

    assign operand_b = (ACC & ~FIRST) ? acc_q : I2;

    always_comb begin
        result_d = '0;
        case (OP)
            3'b000: result_d = I1 & operand_b;
            3'b001: result_d = I1 | operand_b;
            3'b010: result_d = I1 ^ operand_b;
            3'b011: result_d = ~(I1 & operand_b);
            3'b100: result_d = ~(I1 | operand_b);
            3'b101: result_d = ~(I1 ^ operand_b);
            3'b110: result_d = ~I1;
            3'b111: result_d = I1;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        acc_d    = acc_q;
        count_d  = count_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            acc_d    = result_d;
            count_d  = count_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({accept, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: O is masked to zero whenever the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= result_d;
        end
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb/tb_logic_gate_pipe.sv - self-checking bench for logic_gate_pipe
module tb_logic_gate_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic [WIDTH-1:0] I1, I2;
    logic [2:0]       OP;
    logic             ACC, FIRST, IN_VALID, OUT_READY;
    logic             IN_READY, OUT_VALID;
    logic [WIDTH-1:0] O;
    logic [CNT_W-1:0] COUNT;
`ifdef LGP_PARITY_EN
    logic             O_PAR;
`endif

    logic_gate_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .I1(I1), .I2(I2), .OP(OP), .ACC(ACC), .FIRST(FIRST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .O(O), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .COUNT(COUNT)
`ifdef LGP_PARITY_EN
        , .O_PAR(O_PAR)
`endif
    );

    always #5 CLK = ~CLK;

    int nchecks = 0;
    int nerr = 0;

    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] macc = '0;
    logic [CNT_W-1:0] mcnt = '0;

    typedef struct {
        logic [7:0] i1;
        logic [7:0] i2;
        logic [2:0] op;
        logic       acc;
        logic       first;
        logic [7:0] exp;
    } vec_t;
    vec_t tv[11];

    function automatic logic [WIDTH-1:0] gate(logic [2:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] ones;
        ones = '1;
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ones - (a & b);
            3'd4: return ones - (a | b);
            3'd5: return ones - (a ^ b);
            3'd6: return ones - a;
            default: return a;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model, then advance both across one clock edge.
    task automatic cycle();
        logic             ev, er, acc_now, pop_now;
        logic [WIDTH-1:0] eo, r;
        #1;
        ev = (mq.size() != 0);
        eo = ev ? mq[0] : '0;
        er = (mq.size() < DEPTH) && !RST;
        check("out_valid", 32'(OUT_VALID), 32'(ev));
        check("o", 32'(O), 32'(eo));
        check("in_ready", 32'(IN_READY), 32'(er));
        check("count", 32'(COUNT), 32'(mcnt));
`ifdef LGP_PARITY_EN
        check("o_par", 32'(O_PAR), 32'($countones(eo) % 2));
`endif
        acc_now = IN_VALID && er;
        pop_now = ev && OUT_READY;
        if (RST) begin
            mq.delete();
            macc = '0;
            mcnt = '0;
        end else begin
            if (pop_now) void'(mq.pop_front());
            if (acc_now) begin
                r = gate(OP, I1, (ACC && !FIRST) ? macc : I2);
                mq.push_back(r);
                macc = r;
                mcnt = mcnt + 1'b1;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        for (int k = 0; k < 8 && mq.size() != 0; k++) cycle();
        check("drained", 32'(OUT_VALID), 32'd0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cycle();
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CNT_W-1:0] c0;
        tv[0]  = '{8'hC5, 8'h3A, 3'd0, 1'b0, 1'b0, 8'h00};
        tv[1]  = '{8'hC5, 8'h3A, 3'd1, 1'b0, 1'b0, 8'hFF};
        tv[2]  = '{8'hC5, 8'h3A, 3'd2, 1'b0, 1'b0, 8'hFF};
        tv[3]  = '{8'hC5, 8'h3A, 3'd3, 1'b0, 1'b0, 8'hFF};
        tv[4]  = '{8'hC5, 8'h3A, 3'd4, 1'b0, 1'b0, 8'h00};
        tv[5]  = '{8'hC5, 8'h3A, 3'd5, 1'b0, 1'b0, 8'h00};
        tv[6]  = '{8'hC5, 8'h3A, 3'd6, 1'b0, 1'b0, 8'h3A};
        tv[7]  = '{8'hC5, 8'h3A, 3'd7, 1'b0, 1'b0, 8'hC5};
        tv[8]  = '{8'hFF, 8'hF0, 3'd0, 1'b1, 1'b1, 8'hF0};
        tv[9]  = '{8'h3C, 8'h00, 3'd0, 1'b1, 1'b0, 8'h30};
        tv[10] = '{8'h01, 8'hAA, 3'd1, 1'b1, 1'b0, 8'h31};

        RST = 1'b1; I1 = '0; I2 = '0; OP = '0; ACC = 1'b0; FIRST = 1'b0;
        IN_VALID = 1'b1; OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        cycle();
        cycle();
        RST = 1'b0;

        // Operation table and chain, one accept per cycle with a free consumer.
        for (int i = 0; i < 11; i++) begin
            I1 = tv[i].i1; I2 = tv[i].i2; OP = tv[i].op;
            ACC = tv[i].acc; FIRST = tv[i].first; IN_VALID = 1'b1;
            cycle();
            check("tv_o", 32'(O), 32'(tv[i].exp));
            check("tv_valid", 32'(OUT_VALID), 32'd1);
            if (i == 7) check("count_after_ops", 32'(COUNT), 32'd8);
        end
        drain();

        // Back-pressure: six offered beats, exactly four fit.
        ACC = 1'b0; OUT_READY = 1'b0; IN_VALID = 1'b1;
        c0 = COUNT;
        for (int k = 0; k < 6; k++) begin
            I1 = 8'($urandom); I2 = 8'($urandom); OP = 3'($urandom);
            cycle();
        end
        check("bp_accepts", 32'(CNT_W'(COUNT - c0)), 32'd4);
        check("bp_in_ready", 32'(IN_READY), 32'd0);
        OUT_READY = 1'b1;
        cycle();
        check("bp_ready_back", 32'(IN_READY), 32'd1);
        for (int k = 0; k < 4; k++) begin
            I1 = 8'($urandom); OP = 3'($urandom);
            cycle();
        end
        drain();

        // Steady push/pop at occupancy two.
        OUT_READY = 1'b0; IN_VALID = 1'b1;
        cycle();
        cycle();
        OUT_READY = 1'b1;
        for (int k = 0; k < 10; k++) begin
            I1 = 8'($urandom); I2 = 8'($urandom); OP = 3'($urandom);
            ACC = 1'($urandom); FIRST = 1'($urandom);
            cycle();
            check("pp_valid", 32'(OUT_VALID), 32'd1);
        end
        drain();

        // Reset with three results buffered and accumulator A5.
        ACC = 1'b0; OP = 3'd7; I1 = 8'hA5; OUT_READY = 1'b0; IN_VALID = 1'b1;
        cycle(); cycle(); cycle();
        check("rm_three", 32'(OUT_VALID), 32'd1);
        RST = 1'b1;
        cycle();
        RST = 1'b0; IN_VALID = 1'b0;
        #1;
        check("rm_out_valid", 32'(OUT_VALID), 32'd0);
        check("rm_count", 32'(COUNT), 32'd0);
        IN_VALID = 1'b1; ACC = 1'b1; FIRST = 1'b0; OP = 3'd1; I1 = 8'h00; I2 = 8'hFF;
        OUT_READY = 1'b1;
        cycle();
        check("rm_chain_o", 32'(O), 32'h00);
        check("rm_chain_valid", 32'(OUT_VALID), 32'd1);

        // Counter wrap and parity.
        do_reset();
        ACC = 1'b0; OP = 3'd7; IN_VALID = 1'b1; OUT_READY = 1'b1;
        for (int k = 0; k < 17; k++) begin
            I1 = (k == 15) ? 8'h07 : (k == 16) ? 8'h03 : 8'(k);
            cycle();
`ifdef LGP_PARITY_EN
            if (k == 15) check("par_07", 32'(O_PAR), 32'd1);
            if (k == 16) check("par_03", 32'(O_PAR), 32'd0);
`endif
        end
        check("wrap_count", 32'(COUNT), 32'd1);
        check("wrap_o", 32'(O), 32'h03);
        drain();

        // Random traffic against the model.
        for (int k = 0; k < 500; k++) begin
            RST = ($urandom_range(0, 59) == 0);
            IN_VALID = 1'($urandom);
            OUT_READY = ($urandom_range(0, 3) != 0);
            I1 = 8'($urandom); I2 = 8'($urandom); OP = 3'($urandom);
            ACC = 1'($urandom); FIRST = ($urandom_range(0, 3) == 0);
            cycle();
        end
        RST = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/logic_gate_pipe.md
# logic_gate_pipe

Parametrised, handshaked successor to the two-input single-gate top module. Applies one of eight bitwise logic operations to two WIDTH-bit operands, or chains results through an internal accumulator, and buffers results in a DEPTH-entry output FIFO with valid/ready flow control on both sides. Sits between the lab operand source and any downstream consumer, so back-pressure never drops a result.

## Interface
- WIDTH, 8, operand/result width (≥1)
- DEPTH, 4, output FIFO entries (power of two, ≥2)
- CNT_W, 16, width of transaction counter
- Clocking: one clock; reset is synchronous and active-high. Ports are CLK and RST.
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous active-high reset
- I1  in  WIDTH  operand A
- I2  in  WIDTH  operand B (ignored in chain mode unless FIRST=1)
- OP  in  3  operation select
- ACC  in  1  chain mode: operand B taken from accumulator
- FIRST  in  1  with ACC=1, seed chain: operand B taken from I2
- IN_VALID  in  1  operand beat valid
- IN_READY  out  1  block can accept a beat
- O  out  WIDTH  FIFO head result
- OUT_VALID  out  1  O holds a valid result
- OUT_READY  in  1  consumer takes head this cycle
- COUNT  out  CNT_W  accepted-beat counter
- O_PAR  out  1  even parity of O (only with LGP_PARITY_EN)

## Operation
- Accept = IN_VALID & IN_READY. Pop = OUT_VALID & OUT_READY.
- OP encoding, B = selected operand B: 000 A&B, 001 A|B, 010 A^B, 011 ~(A&B), 100 ~(A|B), 101 ~(A^B), 110 ~A, 111 A (buffer).
- Operand B: ACC=0 → I2; ACC=1,FIRST=1 → I2; ACC=1,FIRST=0 → accumulator. FIRST ignored when ACC=0.
- On every accept, the result is pushed into the FIFO. The accumulator is loaded with the result, regardless of ACC. Accumulator not updated without accept.
- COUNT increments by 1 on every accept, wraps 2^CNT_W−1 → 0.
- FIFO: occupancy 0..DEPTH; read/write pointers wrap modulo DEPTH. O = head entry when OUT_VALID=1, all-zero when empty.
- IN_READY = (occupancy < DEPTH) & ~RST. No combinational path from OUT_READY to IN_READY: when full, IN_READY=0 even if a pop occurs that cycle.
- Simultaneous accept and pop at 0 < occupancy < DEPTH: occupancy unchanged, both pointers advance.
- Accept at occupancy 0: entry written. OUT_VALID rises next cycle. No same-cycle bypass.
- OUT_READY while OUT_VALID=0: no effect.
- Inputs I1/I2/OP/ACC/FIRST are sampled only on accept. Their values are don't-care otherwise.

## Timing
- Reset values, held while RST=1 and through the first edge: occupancy 0, pointers 0, accumulator 0, COUNT 0, OUT_VALID 0, O 0, O_PAR 0, IN_READY 0.
- IN_READY=1 in the first cycle after RST deasserts.
- RST mid-operation discards all buffered results and the accumulator on that edge. A beat presented in that cycle is not accepted.
- Latency: accept at edge n → OUT_VALID=1 with result on O after edge n (visible cycle n+1).
- Throughput: 1 beat/cycle sustained while OUT_READY=1.
- Chain dependence: back-to-back accepts with ACC=1 use the accumulator value written by the previous accept. No bubble is required.
- FIFO full after DEPTH accepts without pops. IN_READY falls in the cycle after the DEPTH-th accept and rises in the cycle after the first pop.

## Configuration
- LGP_PARITY_EN defined: O_PAR port exists, O_PAR = ^O, combinational from head, 0 when empty.
- LGP_PARITY_EN undefined: O_PAR port and its logic absent. All other behaviour identical.

## Test plan
- Reset/ops (WIDTH=8): release RST. With OUT_READY=1, send I1=8'hC5, I2=8'h3A with OP 000..111 on consecutive cycles. Required O sequence: 00, FF, FF, FF, 00, 00, 3A, C5, each one cycle after its accept. COUNT reaches 8.
- Chain: OP=000, ACC=1, FIRST=1, I1=FF, I2=F0 → F0. Then FIRST=0, I1=3C → 30. Then OP=001, I1=01 → 31. Outputs arrive on three consecutive cycles.
- Back-pressure: OUT_READY=0, IN_VALID=1 for 6 cycles with DEPTH=4. Exactly 4 accepts occur and IN_READY=0 afterwards. Then set OUT_READY=1 and hold IN_VALID=1. Results pop in order with no loss and no duplication, and IN_READY returns one cycle after the first pop.
- Simultaneous push/pop at occupancy 2 for 10 cycles: occupancy stays 2, pointers wrap, output order is preserved.
- Reset mid-burst: with 3 entries buffered and an accumulator of A5, assert RST for one cycle. OUT_VALID=0, COUNT=0, then ACC=1,FIRST=0,OP=001,I1=00 → O=00 (accumulator was cleared).
- Wrap/parity (CNT_W=4, LGP_PARITY_EN): 17 accepts → COUNT=1. For O=8'h07, O_PAR=1. For O=8'h03, O_PAR=0.
